// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor: one inverse round per enabled cycle, round keys walked backwards on the fly.
// Optional macro AES_DEC_KEY_EXPAND_EN: key_i is the cipher key and is first expanded forward to round 10.
module aes_dec_iter #(
    parameter int         NR     = 10,
    parameter logic [7:0] RCON10 = 8'h36
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         start_i,
    input  logic [127:0] cipher_i,
    input  logic [127:0] key_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] plain_o
);

    if (NR != 10) begin : g_nr_unsupported
        $error("aes_dec_iter: only NR=10 (AES-128) is supported");
    end

    // Byte 0 is the most significant byte of the 128-bit block, column-major like FIPS-197.
    typedef logic [0:15][7:0] block_t;

`ifdef AES_DEC_KEY_EXPAND_EN
    typedef enum logic [1:0] {IDLE, RUN, EXPAND} fsm_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} fsm_t;
`endif

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    // Row r moves right by r columns.
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c + r] = s[4*((c - r + 4) % 4) + r];
        return o;
    endfunction

    function automatic block_t inv_sub_bytes(input block_t s);
        block_t o;
        for (int i = 0; i < 16; i++) o[i] = INV_SBOX[s[i]];
        return o;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t o;
        for (int c = 0; c < 4; c++) begin
            o[4*c]   = gf_mul(s[4*c], 4'he) ^ gf_mul(s[4*c+1], 4'hb) ^ gf_mul(s[4*c+2], 4'hd) ^ gf_mul(s[4*c+3], 4'h9);
            o[4*c+1] = gf_mul(s[4*c], 4'h9) ^ gf_mul(s[4*c+1], 4'he) ^ gf_mul(s[4*c+2], 4'hb) ^ gf_mul(s[4*c+3], 4'hd);
            o[4*c+2] = gf_mul(s[4*c], 4'hd) ^ gf_mul(s[4*c+1], 4'h9) ^ gf_mul(s[4*c+2], 4'he) ^ gf_mul(s[4*c+3], 4'hb);
            o[4*c+3] = gf_mul(s[4*c], 4'hb) ^ gf_mul(s[4*c+1], 4'hd) ^ gf_mul(s[4*c+2], 4'h9) ^ gf_mul(s[4*c+3], 4'he);
        end
        return o;
    endfunction

    // Undo one forward key-schedule step: recover round k-1 from round k.
    function automatic logic [127:0] prev_round_key(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] b0, b1, b2, b3;
        b3 = rk[31:0]   ^ rk[63:32];
        b2 = rk[63:32]  ^ rk[95:64];
        b1 = rk[95:64]  ^ rk[127:96];
        b0 = rk[127:96] ^ sub_rot_word(b3) ^ {rcon, 24'h0};
        return {b0, b1, b2, b3};
    endfunction

`ifdef AES_DEC_KEY_EXPAND_EN
    function automatic logic [127:0] next_round_key(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] f0, f1, f2, f3;
        f0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rcon, 24'h0};
        f1 = f0 ^ rk[95:64];
        f2 = f1 ^ rk[63:32];
        f3 = f2 ^ rk[31:0];
        return {f0, f1, f2, f3};
    endfunction
`endif

    fsm_t         fsm_q, fsm_d;
    block_t       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_q, done_d;
    logic [127:0] plain_q, plain_d;
    logic [127:0] rk_prev;
    block_t       inv_core;
`ifdef AES_DEC_KEY_EXPAND_EN
    logic [127:0] rk_fwd;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        rk_prev  = prev_round_key(rk_q, rcon_q);
        inv_core = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_prev;
`ifdef AES_DEC_KEY_EXPAND_EN
        rk_fwd   = next_round_key(rk_q, rcon_q);
`endif
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        plain_d = plain_q;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    rk_d  = key_i;
                    cnt_d = 4'(NR - 1);
`ifdef AES_DEC_KEY_EXPAND_EN
                    state_d = cipher_i;
                    rcon_d  = 8'h01;
                    fsm_d   = EXPAND;
`else
                    state_d = cipher_i ^ key_i;
                    rcon_d  = RCON10;
                    fsm_d   = RUN;
`endif
                end
            end
`ifdef AES_DEC_KEY_EXPAND_EN
            EXPAND: begin
                rk_d   = rk_fwd;
                rcon_d = xtime(rcon_q);
                if (cnt_q == 4'd0) begin
                    state_d = state_q ^ rk_fwd;
                    rcon_d  = RCON10;
                    cnt_d   = 4'(NR - 1);
                    fsm_d   = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            RUN: begin
                rk_d   = rk_prev;
                rcon_d = (rcon_q == 8'h1b) ? 8'h80 : {1'b0, rcon_q[7:1]};
                if (cnt_q != 4'd0) begin
                    state_d = inv_mix_columns(inv_core);
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    plain_d = inv_core;
                    done_d  = 1'b1;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments with an async reset; en=0 freezes every register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rcon_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            plain_q <= '0;
        end else if (en) begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            plain_q <= plain_d;
        end
    end

    assign busy_o  = (fsm_q != IDLE);
    assign done_o  = done_q;
    assign plain_o = plain_q;

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter: FIPS-197 vectors through a plaintext scoreboard, plus stall, back-to-back and reset cases.
// Build with AES_DEC_KEY_EXPAND_EN to drive cipher keys and expect the 20-edge latency instead.
module tb_aes_dec_iter;

    logic         clk = 1'b0;
    logic         nrst;
    logic         en;
    logic         start_i;
    logic [127:0] cipher_i;
    logic [127:0] key_i;
    logic         busy_o;
    logic         done_o;
    logic [127:0] plain_o;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_KEY_EXPAND_EN
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam int           LAT = 20;
`else
    localparam logic [127:0] K1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam int           LAT = 10;
`endif

    aes_dec_iter dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .start_i  (start_i),
        .cipher_i (cipher_i),
        .key_i    (key_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .plain_o  (plain_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input string tag, input logic [127:0] c, input logic [127:0] k,
                               input logic [127:0] p, input bit push);
        start_i  = 1'b1;
        cipher_i = c;
        key_i    = k;
        tick();
        start_i  = 1'b0;
        cipher_i = {$urandom, $urandom, $urandom, $urandom};
        key_i    = {$urandom, $urandom, $urandom, $urandom};
        if (push) exp_q.push_back(p);
        check({tag, "_busy_on_accept"}, 128'(busy_o), 128'd1);
        check({tag, "_done_low_on_accept"}, 128'(done_o), 128'd0);
    endtask

    // Waits for done_o, optionally stalling or pulsing a stray start, then pops the scoreboard.
    task automatic wait_done(input string tag, input int lat, input int stall_at, input int stall_len,
                             input int pulse_at);
        int           cnt;
        bit           seen;
        logic [127:0] want;
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 100 && !seen) begin
            tick();
            cnt++;
            if (!en) check({tag, "_busy_in_stall"}, 128'(busy_o), 128'd1);
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (cnt == stall_at) en = 1'b0;
                if (cnt == stall_at + stall_len) en = 1'b1;
                start_i = (cnt == pulse_at);
                if (start_i) begin
                    cipher_i = {$urandom, $urandom, $urandom, $urandom};
                    key_i    = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        start_i = 1'b0;
        check({tag, "_done_seen"}, 128'(seen), 128'd1);
        if (seen) begin
            check({tag, "_latency"}, 128'(cnt), 128'(lat));
            check({tag, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check({tag, "_plain"}, plain_o, want);
            end
        end
    endtask

    task automatic idle_check(input string tag, input logic [127:0] p);
        tick();
        check({tag, "_done_pulse_end"}, 128'(done_o), 128'd0);
        check({tag, "_busy_idle"}, 128'(busy_o), 128'd0);
        check({tag, "_plain_held"}, plain_o, p);
    endtask

    initial begin
        int stray_done;
        nrst     = 1'b0;
        en       = 1'b1;
        start_i  = 1'b0;
        cipher_i = '0;
        key_i    = '0;
        #12;
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_done", 128'(done_o), 128'd0);
        check("rst_plain", plain_o, 128'd0);
        nrst = 1'b1;
        tick();
        check("post_rst_busy", 128'(busy_o), 128'd0);

        // FIPS-197 C.1
        start_block("t1", C1, K1, P1, 1'b1);
        wait_done("t1", LAT, 0, 0, 0);
        idle_check("t1", P1);

        // FIPS-197 B, with en dropped in the done cycle: done_o must hold.
        start_block("t2", C2, K2, P2, 1'b1);
        wait_done("t2", LAT, 0, 0, 0);
        en = 1'b0;
        tick();
        check("t2_done_held_by_stall", 128'(done_o), 128'd1);
        en = 1'b1;
        idle_check("t2", P2);

        // Three stalled cycles mid-run.
        start_block("t3", C1, K1, P1, 1'b1);
        wait_done("t3", LAT + 3, 4, 3, 0);
        idle_check("t3", P1);

        // Back-to-back with a stray start while busy.
        start_block("t4a", C1, K1, P1, 1'b1);
        wait_done("t4a", LAT, 0, 0, 3);
        start_block("t4b", C2, K2, P2, 1'b1);
        wait_done("t4b", LAT, 0, 0, 0);
        idle_check("t4", P2);

        // Reset mid-block aborts silently.
        start_block("t5", C1, K1, P1, 1'b0);
        repeat (5) tick();
        #2 nrst = 1'b0;
        #1;
        check("t5_rst_busy", 128'(busy_o), 128'd0);
        check("t5_rst_done", 128'(done_o), 128'd0);
        check("t5_rst_plain", plain_o, 128'd0);
        #3 nrst = 1'b1;
        stray_done = 0;
        repeat (LAT + 5) begin
            tick();
            if (done_o) stray_done++;
        end
        check("t5_no_done_after_abort", 128'(stray_done), 128'd0);
        start_block("t5b", C2, K2, P2, 1'b1);
        wait_done("t5b", LAT, 0, 0, 0);
        idle_check("t5b", P2);

        check("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
